fa_bist_checker: RTL and testbench

- Hardware response-side companion for the 1-bit full adder (FA).
- On a start pulse it drives all 8 {a,b,cin} combinations, in ascending order, into an FA instance.
- For each combination it waits a settle interval, then samples sum/cout and compares them against golden values.
- Reports done, pass, a saturating error count and the first failing vector. Used as built-in self-test beside FA instances and as a reusable checker in benches.

---
 rtl/fa_test_pkg.sv | 29 ++
 rtl/fa_golden.sv | 14 +
 rtl/fa_bist_checker.sv | 171 +++++++++++++++++
 tb/tb_fa_bist_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_test_pkg.sv
// Shared definitions for the full-adder self-test checker.
// Provides the checker state encoding, vector sizing constants and the
// golden full-adder function used by both the RTL and verification code.
package fa_test_pkg;

    // Number of exhaustive {a,b,cin} combinations and their encoding width.
    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;

    // Checker sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } fa_state_e;

    // Golden full-adder response for vector {a,b,cin}; returns {cout,sum}.
    function automatic logic [1:0] fa_expected(input logic [VEC_W-1:0] vec);
        logic op_a;
        logic op_b;
        logic op_c;
        op_a = vec[2];
        op_b = vec[1];
        op_c = vec[0];
        return {(op_a & op_b) | (op_a & op_c) | (op_b & op_c), op_a ^ op_b ^ op_c};
    endfunction

endpackage

// File: rtl/fa_golden.sv
// Combinational expected-value model of a 1-bit full adder.
// Ports:
//   vec_i       {a,b,cin} vector currently applied to the adder under test
//   golden_c_o  expected {cout,sum} for vec_i (combinational)
module fa_golden
    import fa_test_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic [1:0]       golden_c_o
);

    assign golden_c_o = fa_expected(vec_i);

endmodule

// File: rtl/fa_bist_checker.sv
// Response-side built-in self-test for a 1-bit full adder.
// A start pulse sweeps all eight {a,b,cin} vectors in ascending order, holds
// each for SETTLE_CYCLES cycles, then compares sum/cout with golden values.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             launch a run (honoured only in IDLE or DONE)
//   a, b, cin         registered stimulus driven into the adder
//   sum, cout         adder response, sampled only in CHECK
//   busy, done, pass  run status; pass is meaningful while done=1
//   err_count         saturating count of mismatching vectors
//   first_fail_vec    {a,b,cin} of the first mismatch
//   first_fail_valid  first_fail_vec holds a captured vector
module fa_bist_checker
    import fa_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             cin,
    input  logic             sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    // Reject configurations that cannot work.
    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("fa_bist_checker: SETTLE_CYCLES must be >= 1");
        end
        if (ERR_W < 1) begin : g_bad_err_w
            $error("fa_bist_checker: ERR_W must be >= 1");
        end
    endgenerate

    fa_state_e        state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;

    logic [1:0]       golden_c;
    logic             mismatch_c;
    logic [ERR_W-1:0] err_inc_c;

    // Expected adder response for the vector currently driven.
    fa_golden u_golden (
        .vec_i      (vec_q),
        .golden_c_o (golden_c)
    );

    assign mismatch_c = ({cout, sum} != golden_c);
    assign err_inc_c  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);

    // Next-state and result update logic.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    vec_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end

            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CHECK: begin
                if (mismatch_c) begin
                    err_d = err_inc_c;
                    // Only the first failing vector of a run is kept.
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    // Stimulus stays parked on the last vector while in DONE.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = SETTLE;
                    vec_d   = vec_q + VEC_W'(1);
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    // The vector register directly drives the adder operands.
    assign {a, b, cin}      = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Scoreboard bench for fa_bist_checker: two instances (default parameters and
// SETTLE_CYCLES=1/ERR_W=2) share one configurable faulty full-adder table.
module tb_fa_bist_checker;

    typedef struct {
        int start_cyc;
        int err;
        int ffv;
        int ffvl;
        int pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic a0, b0, c0, s0, co0, busy0, done0, pass0, ffvl0;
    logic [3:0] err0;
    logic [2:0] ffv0;
    logic a1, b1, c1, s1, co1, busy1, done1, pass1, ffvl1;
    logic [1:0] err1;
    logic [2:0] ffv1;

    logic [1:0] tab [8];   // adder response per vector: {cout,sum}
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    assign {co0, s0} = tab[{a0, b0, c0}];
    assign {co1, s1} = tab[{a1, b1, c1}];

    fa_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .a(a0), .b(b0), .cin(c0), .sum(s0), .cout(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvl0)
    );

    fa_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .a(a1), .b(b1), .cin(c1), .sum(s1), .cout(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffvl1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic full adder: count of ones gives sum (odd) and carry (>=2).
    function automatic logic [1:0] gold(input int v);
        int n;
        logic [1:0] r;
        n = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
        r[0] = ((n % 2) == 1);
        r[1] = (n >= 2);
        return r;
    endfunction

    // Expected run result from the current adder table.
    function automatic exp_t model(input int sc, input int emax);
        exp_t e;
        int cnt;
        cnt = 0;
        e.start_cyc = sc;
        e.ffv = 0;
        e.ffvl = 0;
        for (int v = 0; v < 8; v++) begin
            if (tab[v] != gold(v)) begin
                cnt++;
                if (e.ffvl == 0) begin
                    e.ffv = v;
                    e.ffvl = 1;
                end
            end
        end
        e.err = (cnt > emax) ? emax : cnt;
        e.pass = (cnt == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_zero(input int d, input logic bsy, input logic dn, input logic ps,
                            input int err, input int ffv, input logic ffvl, input int abc);
        chk("rst_busy", d, int'(bsy), 0);
        chk("rst_done", d, int'(dn), 0);
        chk("rst_pass", d, int'(ps), 0);
        chk("rst_err", d, err, 0);
        chk("rst_ffv", d, ffv, 0);
        chk("rst_ffvalid", d, int'(ffvl), 0);
        chk("rst_abc", d, abc, 0);
    endtask

    // Monitor step for one instance: compares against the oldest pending run.
    task automatic mon(input int d, input int hold, input logic bsy, input logic dn,
                       input logic ps, input int err, input int ffv, input logic ffvl,
                       input int abc);
        exp_t e;
        int el;
        int total;
        bit have;
        total = 8 * hold;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) begin
            e = (d == 0) ? q0[0] : q1[0];
            el = cyc - e.start_cyc;
            if (dn) begin
                chk("done_latency", d, el, total);
                chk("pass", d, int'(ps), e.pass);
                chk("err_count", d, err, e.err);
                chk("first_fail_valid", d, int'(ffvl), e.ffvl);
                chk("first_fail_vec", d, ffv, e.ffv);
                chk("done_busy", d, int'(bsy), 0);
                chk("done_abc", d, abc, 7);
                if (d == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end else if (el > total + 4) begin
                chk("done_timeout", d, el, total);
                if (d == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end else if (el < total) begin
                chk("run_busy", d, int'(bsy), 1);
                chk("run_abc", d, abc, el / hold);
                if (el == 0) begin
                    chk("start_err_clr", d, err, 0);
                    chk("start_ffvalid_clr", d, int'(ffvl), 0);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, 3, busy0, done0, pass0, int'(err0), int'(ffv0), ffvl0, int'({a0, b0, c0}));
        mon(1, 2, busy1, done1, pass1, int'(err1), int'(ffv1), ffvl1, int'({a1, b1, c1}));
    end

    // 0 correct, 1 cout stuck-at-0, 2 sum inverted, 3 random corruption.
    task automatic set_tab(input int mode);
        logic [1:0] g;
        for (int v = 0; v < 8; v++) begin
            g = gold(v);
            case (mode)
                0: tab[v] = g;
                1: tab[v] = {1'b0, g[0]};
                2: tab[v] = g ^ 2'b01;
                default: tab[v] = ($urandom_range(0, 3) == 0) ? (g ^ 2'($urandom_range(1, 3))) : g;
            endcase
        end
    endtask

    // One run; optional extra start pulse or reset at negedge number n after launch.
    task automatic run_one(input int mid_start, input int abort_at);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q0.push_back(model(cyc, 15));
        q1.push_back(model(cyc, 3));
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
            start = (n == mid_start);
            if (n == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                q0.delete();
                q1.delete();
                chk_zero(0, busy0, done0, pass0, int'(err0), int'(ffv0), ffvl0, int'({a0, b0, c0}));
                chk_zero(1, busy1, done1, pass1, int'(err1), int'(ffv1), ffvl1, int'({a1, b1, c1}));
                @(negedge clk);
                rst = 1'b0;
            end
        end
        start = 1'b0;
        if (n >= 60) begin
            chk("run_timeout", 0, n, 0);
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        set_tab(0);
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, busy0, done0, pass0, int'(err0), int'(ffv0), ffvl0, int'({a0, b0, c0}));
        chk_zero(1, busy1, done1, pass1, int'(err1), int'(ffv1), ffvl1, int'({a1, b1, c1}));
        @(negedge clk);
        rst = 1'b0;

        // Reset and start together: reset wins, stays idle.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk_zero(0, busy0, done0, pass0, int'(err0), int'(ffv0), ffvl0, int'({a0, b0, c0}));
        chk_zero(1, busy1, done1, pass1, int'(err1), int'(ffv1), ffvl1, int'({a1, b1, c1}));
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 0, int'(busy0), 0);
        chk("idle_busy", 1, int'(busy1), 0);

        set_tab(0); run_one(-1, -1);   // clean run
        set_tab(0); run_one(-1, -1);   // restart straight from DONE
        set_tab(1); run_one(-1, -1);   // cout stuck-at-0
        set_tab(2); run_one(-1, -1);   // sum inverted, saturates on narrow counter
        set_tab(0); run_one(6, -1);    // start while busy is ignored
        set_tab(2); run_one(-1, 14);   // reset while vector 100 is held
        set_tab(0); run_one(-1, -1);   // clean run after abort
        repeat (10) begin
            set_tab(3);
            run_one(-1, -1);
        end
        set_tab(3); run_one(int'($urandom_range(2, 15)), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
